// File: rtl/calc_result_scoreboard_pkg.sv
// Shared types and helpers for the calculator result scoreboard.
package calc_result_scoreboard_pkg;

    localparam int MAX_NCH = 8;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_WAIT = 2'd1,
        CHK_TOUT = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic match;
        logic mism;
        logic unexp;
        logic ovf;
        logic tout;
    } chk_evt_t;

    function automatic logic [3:0] popcount_nch(input logic [MAX_NCH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/calc_sb_fifo.sv
// Per-channel expected-result FIFO; a push while full is accepted only alongside a pop.
module calc_sb_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/calc_result_scoreboard.sv
// Multi-channel in-order scoreboard: queues expected results, compares DUT results
// under a mask, aggregates match/mismatch counts, sticky errors and first-failure capture.
//
// state    | meaning
// CHK_IDLE | channel FIFO empty, nothing to age
// CHK_WAIT | head entry waiting, age counter running
// CHK_TOUT | head entry exceeded TIMEOUT, compare still active
module calc_result_scoreboard
    import calc_result_scoreboard_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     cmp_mask,
    input  logic [NCH-1:0]        exp_valid,
    input  logic [NCH*DATA_W-1:0] exp_data,
    output logic [NCH-1:0]        exp_ready,
    input  logic [NCH-1:0]        act_valid,
    input  logic [NCH*DATA_W-1:0] act_data,
    output logic [CNT_W-1:0]      match_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [NCH-1:0]        err_mismatch,
    output logic [NCH-1:0]        err_unexpect,
    output logic [NCH-1:0]        err_overflow,
    output logic [NCH-1:0]        err_timeout,
    output logic                  first_vld,
    output logic [CH_W-1:0]       first_ch,
    output logic [DATA_W-1:0]     first_exp,
    output logic [DATA_W-1:0]     first_act
);

    localparam int CNT_FW = $clog2(DEPTH) + 1;
    localparam int AGE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [DATA_W-1:0] head   [NCH];
    logic [CNT_FW-1:0] fcount [NCH];
    chk_evt_t          evt    [NCH];
    logic [NCH-1:0]    fempty;
    logic [NCH-1:0]    ffull;
    logic [NCH-1:0]    pop;
    logic [NCH-1:0]    push_acc;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        chk_state_e        state_q;
        chk_state_e        state_d;
        logic [AGE_W-1:0]  age_q;
        logic [AGE_W-1:0]  age_d;
        logic              rdy_q;
        logic              tout;
        logic              hit;
        logic              last_pop;
        logic [DATA_W-1:0] act;
        logic [CNT_FW-1:0] cnt_nxt;

        calc_sb_fifo #(
            .DEPTH (DEPTH),
            .DATA_W(DATA_W)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .push (push_acc[c]),
            .pop  (pop[c]),
            .wdata(exp_data[c*DATA_W +: DATA_W]),
            .rdata(head[c]),
            .count(fcount[c]),
            .full (ffull[c]),
            .empty(fempty[c])
        );

        assign act         = act_data[c*DATA_W +: DATA_W];
        assign pop[c]      = act_valid[c] & ~fempty[c];
        // A full FIFO still takes a push when the head leaves in the same cycle.
        assign push_acc[c] = exp_valid[c] & (~ffull[c] | pop[c]);
        assign exp_ready[c] = rdy_q;
        assign hit         = (((head[c] ^ act) & cmp_mask) == '0);
        assign last_pop    = pop[c] & ~push_acc[c] & (fcount[c] == CNT_FW'(1));
        assign cnt_nxt     = fcount[c] + CNT_FW'(push_acc[c]) - CNT_FW'(pop[c]);

        assign evt[c] = '{match: pop[c] & hit,
                          mism:  pop[c] & ~hit,
                          unexp: act_valid[c] & fempty[c],
                          ovf:   exp_valid[c] & ffull[c] & ~pop[c],
                          tout:  tout};

        always_comb begin
            state_d = state_q;
            age_d   = age_q;
            tout    = 1'b0;
            case (state_q)
                CHK_IDLE: begin
                    if (push_acc[c]) begin
                        state_d = CHK_WAIT;
                        age_d   = '0;
                    end
                end
                CHK_WAIT: begin
                    if (pop[c]) begin
                        state_d = last_pop ? CHK_IDLE : CHK_WAIT;
                        age_d   = '0;
                    end else if ((TIMEOUT != 0) && (age_q == AGE_MAX)) begin
                        state_d = CHK_TOUT;
                        tout    = 1'b1;
                    end else begin
                        age_d = age_q + AGE_W'(1);
                    end
                end
                CHK_TOUT: begin
                    if (pop[c]) begin
                        state_d = last_pop ? CHK_IDLE : CHK_WAIT;
                        age_d   = '0;
                    end
                end
                default: begin
                    state_d = CHK_IDLE;
                    age_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= CHK_IDLE;
                age_q   <= '0;
                rdy_q   <= 1'b1;
            end else if (clr) begin
                state_q <= CHK_IDLE;
                age_q   <= '0;
                rdy_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                age_q   <= age_d;
                rdy_q   <= (cnt_nxt != CNT_FW'(DEPTH));
            end
        end
    end

    logic [NCH-1:0]     match_v;
    logic [NCH-1:0]     mism_v;
    logic [NCH-1:0]     unexp_v;
    logic [NCH-1:0]     ovf_v;
    logic [NCH-1:0]     tout_v;
    logic [NCH-1:0]     fail_v;
    logic [MAX_NCH-1:0] match_pad;
    logic [MAX_NCH-1:0] fail_pad;
    logic [CNT_W:0]     match_sum;
    logic [CNT_W:0]     mism_sum;
    logic [CH_W-1:0]    fail_ch;
    logic [DATA_W-1:0]  fail_exp;
    logic [DATA_W-1:0]  fail_act;

    always_comb begin
        match_v = '0;
        mism_v  = '0;
        unexp_v = '0;
        ovf_v   = '0;
        tout_v  = '0;
        for (int c = 0; c < NCH; c++) begin
            match_v[c] = evt[c].match;
            mism_v[c]  = evt[c].mism;
            unexp_v[c] = evt[c].unexp;
            ovf_v[c]   = evt[c].ovf;
            tout_v[c]  = evt[c].tout;
        end
        fail_v = mism_v | unexp_v;

        // Descending scan so the lowest failing channel is the one left standing.
        fail_ch  = '0;
        fail_exp = '0;
        fail_act = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (fail_v[c]) begin
                fail_ch  = CH_W'(c);
                fail_exp = unexp_v[c] ? '0 : head[c];
                fail_act = act_data[c*DATA_W +: DATA_W];
            end
        end

        match_pad            = '0;
        match_pad[NCH-1:0]   = match_v;
        fail_pad             = '0;
        fail_pad[NCH-1:0]    = fail_v;
        match_sum = {1'b0, match_cnt}    + (CNT_W+1)'(popcount_nch(match_pad));
        mism_sum  = {1'b0, mismatch_cnt} + (CNT_W+1)'(popcount_nch(fail_pad));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err_mismatch <= '0;
            err_unexpect <= '0;
            err_overflow <= '0;
            err_timeout  <= '0;
            first_vld    <= 1'b0;
            first_ch     <= '0;
            first_exp    <= '0;
            first_act    <= '0;
        end else if (clr) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err_mismatch <= '0;
            err_unexpect <= '0;
            err_overflow <= '0;
            err_timeout  <= '0;
            first_vld    <= 1'b0;
            first_ch     <= '0;
            first_exp    <= '0;
            first_act    <= '0;
        end else begin
            match_cnt    <= match_sum[CNT_W] ? '1 : match_sum[CNT_W-1:0];
            mismatch_cnt <= mism_sum[CNT_W]  ? '1 : mism_sum[CNT_W-1:0];
            err_mismatch <= err_mismatch | mism_v;
            err_unexpect <= err_unexpect | unexp_v;
            err_overflow <= err_overflow | ovf_v;
            err_timeout  <= err_timeout  | tout_v;
            if (!first_vld && (|fail_v)) begin
                first_vld <= 1'b1;
                first_ch  <= fail_ch;
                first_exp <= fail_exp;
                first_act <= fail_act;
            end
        end
    end

endmodule

// File: tb/tb_calc_result_scoreboard.sv
// Directed bench for calc_result_scoreboard with a queue-based reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_calc_result_scoreboard;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 4;
    localparam int TO    = 8;
    localparam int CMAX  = 15;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              clr       = 1'b0;
    logic [DW-1:0]     cmp_mask  = '1;
    logic [NCH-1:0]    exp_valid = '0;
    logic [NCH-1:0]    act_valid = '0;
    logic [NCH*DW-1:0] exp_data  = '0;
    logic [NCH*DW-1:0] act_data  = '0;

    logic [NCH-1:0] exp_ready;
    logic [CW-1:0]  match_cnt;
    logic [CW-1:0]  mismatch_cnt;
    logic [NCH-1:0] err_mismatch;
    logic [NCH-1:0] err_unexpect;
    logic [NCH-1:0] err_overflow;
    logic [NCH-1:0] err_timeout;
    logic           first_vld;
    logic [1:0]     first_ch;
    logic [DW-1:0]  first_exp;
    logic [DW-1:0]  first_act;

    always #5 clk = ~clk;

    calc_result_scoreboard #(
        .NCH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cmp_mask(cmp_mask),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .act_valid(act_valid), .act_data(act_data),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
        .err_mismatch(err_mismatch), .err_unexpect(err_unexpect),
        .err_overflow(err_overflow), .err_timeout(err_timeout),
        .first_vld(first_vld), .first_ch(first_ch),
        .first_exp(first_exp), .first_act(first_act)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: one queue of expected values per channel.
    logic [DW-1:0]  mq [NCH][$];
    int             m_wait [NCH];
    int             m_match = 0;
    int             m_mism  = 0;
    logic [NCH-1:0] m_emis  = '0;
    logic [NCH-1:0] m_eune  = '0;
    logic [NCH-1:0] m_eovf  = '0;
    logic [NCH-1:0] m_etou  = '0;
    bit             m_fv    = 0;
    int             m_fch   = 0;
    logic [DW-1:0]  m_fexp  = '0;
    logic [DW-1:0]  m_fact  = '0;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_wait[c] = 0;
        end
        m_match = 0; m_mism = 0;
        m_emis = '0; m_eune = '0; m_eovf = '0; m_etou = '0;
        m_fv = 0; m_fch = 0; m_fexp = '0; m_fact = '0;
    endtask

    task automatic model_step();
        bit            do_pop  [NCH];
        bit            do_push [NCH];
        bit            got_first;
        int            nm;
        int            nf;
        logic [DW-1:0] a;
        nm = 0; nf = 0; got_first = 0;
        for (int c = 0; c < NCH; c++) begin
            a = act_data[c*DW +: DW];
            do_pop[c]  = act_valid[c] && (mq[c].size() > 0);
            do_push[c] = exp_valid[c] && ((mq[c].size() < DEPTH) || do_pop[c]);
            if (exp_valid[c] && !do_push[c]) m_eovf[c] = 1'b1;
            if (do_pop[c]) begin
                if (((mq[c][0] ^ a) & cmp_mask) == '0) begin
                    nm++;
                end else begin
                    nf++;
                    m_emis[c] = 1'b1;
                    if (!m_fv && !got_first) begin
                        got_first = 1; m_fch = c; m_fexp = mq[c][0]; m_fact = a;
                    end
                end
                m_wait[c] = 0;
            end else begin
                if (act_valid[c]) begin
                    nf++;
                    m_eune[c] = 1'b1;
                    if (!m_fv && !got_first) begin
                        got_first = 1; m_fch = c; m_fexp = '0; m_fact = a;
                    end
                end
                if (mq[c].size() > 0) begin
                    m_wait[c]++;
                    if (m_wait[c] == TO) m_etou[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (do_pop[c])  void'(mq[c].pop_front());
            if (do_push[c]) mq[c].push_back(exp_data[c*DW +: DW]);
        end
        if (got_first) m_fv = 1;
        m_match = (m_match + nm > CMAX) ? CMAX : m_match + nm;
        m_mism  = (m_mism + nf > CMAX)  ? CMAX : m_mism + nf;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   model_reset();
        else if (clr) model_reset();
        else          model_step();
    end

    function automatic logic [NCH-1:0] model_ready();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (mq[c].size() != DEPTH);
        return r;
    endfunction

    always @(negedge clk) begin
        chk("exp_ready",    exp_ready,    model_ready());
        chk("match_cnt",    match_cnt,    m_match);
        chk("mismatch_cnt", mismatch_cnt, m_mism);
        chk("err_mismatch", err_mismatch, m_emis);
        chk("err_unexpect", err_unexpect, m_eune);
        chk("err_overflow", err_overflow, m_eovf);
        chk("err_timeout",  err_timeout,  m_etou);
        chk("first_vld",    first_vld,    m_fv);
        if (m_fv) begin
            chk("first_ch",  first_ch,  m_fch);
            chk("first_exp", first_exp, m_fexp);
            chk("first_act", first_act, m_fact);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid = '0;
        act_valid = '0;
        clr       = 1'b0;
    endtask

    task automatic push(input int c, input logic [DW-1:0] d);
        exp_valid[c] = 1'b1;
        exp_data[c*DW +: DW] = d;
    endtask

    task automatic act(input int c, input logic [DW-1:0] d);
        act_valid[c] = 1'b1;
        act_data[c*DW +: DW] = d;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_exp_ready", exp_ready, 4'hF);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_first_vld", first_vld, 0);

        // in-order matches on ch0
        push(0, 10); tick();
        push(0, 20); tick();
        push(0, 30); tick();
        act(0, 10); tick();
        act(0, 20); tick();
        act(0, 30); tick();
        chk("t1_match_cnt", match_cnt, 3);
        chk("t1_mismatch_cnt", mismatch_cnt, 0);
        chk("t1_flags", {err_mismatch, err_unexpect, err_overflow, err_timeout}, 0);
        do_clr();

        // masked compare on ch1
        cmp_mask = 32'h0000_FFFF;
        push(1, 32'h00FF); tick();
        act(1, 32'h01FF);  tick();
        chk("t2_err_mismatch", err_mismatch, 4'b0010);
        chk("t2_first_vld", first_vld, 1);
        chk("t2_first_ch", first_ch, 1);
        chk("t2_first_exp", first_exp, 32'h00FF);
        chk("t2_first_act", first_act, 32'h01FF);
        cmp_mask = 32'h0000_00FF;
        push(1, 32'h00FF); tick();
        act(1, 32'h01FF);  tick();
        chk("t2_masked_match", match_cnt, 1);
        chk("t2_mismatch_cnt", mismatch_cnt, 1);
        do_clr();
        cmp_mask = '1;

        // unexpected actual, then same-cycle push into empty plus act
        act(2, 32'h55); tick();
        chk("t3_err_unexpect", err_unexpect, 4'b0100);
        chk("t3_mismatch_cnt", mismatch_cnt, 1);
        chk("t3_first_ch", first_ch, 2);
        chk("t3_first_exp", first_exp, 0);
        chk("t3_first_act", first_act, 32'h55);
        push(2, 32'h77); act(2, 32'h77); tick();
        chk("t3_nobypass_mism", mismatch_cnt, 2);
        act(2, 32'h77); tick();
        chk("t3_stored_match", match_cnt, 1);
        do_clr();

        // fill ch3, push+pop at full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            push(3, i); tick();
        end
        chk("t4_ready_full", exp_ready, 4'b0111);
        chk("t4_no_ovf_yet", err_overflow, 0);
        push(3, 32'h100); act(3, 0); tick();
        chk("t4_pushpop_no_ovf", err_overflow, 0);
        chk("t4_pushpop_match", match_cnt, 1);
        chk("t4_still_full", exp_ready, 4'b0111);
        push(3, 32'h200); tick();
        chk("t4_ovf", err_overflow, 4'b1000);
        chk("t4_tout", err_timeout, 4'b1000);
        chk("t4_first_vld", first_vld, 0);
        do_clr();

        // timeout on ch0, late act still matches
        push(0, 32'hAB); tick();
        repeat (7) tick();
        chk("t5_tout_early", err_timeout, 0);
        tick();
        chk("t5_tout", err_timeout, 4'b0001);
        act(0, 32'hAB); tick();
        chk("t5_late_match", match_cnt, 1);
        chk("t5_late_mism", mismatch_cnt, 0);
        repeat (10) tick();
        do_clr();

        // all channels at once, then saturation
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < NCH; c++) push(c, c * 3 + r);
            tick();
            for (int c = 0; c < NCH; c++) act(c, c * 3 + r);
            tick();
            if (r == 0) chk("t6_four_match", match_cnt, 4);
            if (r == 3) chk("t6_saturate", match_cnt, 15);
        end
        chk("t6_saturate_hold", match_cnt, 15);
        chk("t6_mism", mismatch_cnt, 0);

        // asynchronous reset mid-stream
        push(0, 1); push(1, 2); act(2, 9); tick();
        chk("t7_pre_first_vld", first_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_match", match_cnt, 0);
        chk("t7_rst_mism", mismatch_cnt, 0);
        chk("t7_rst_ready", exp_ready, 4'hF);
        chk("t7_rst_unexp", err_unexpect, 0);
        chk("t7_rst_first_vld", first_vld, 0);
        chk("t7_rst_first_act", first_act, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        act(1, 2); tick();
        chk("t7_fifo_flushed", err_unexpect, 4'b0010);
        push(1, 5); tick();
        act(1, 5); tick();
        chk("t7_post_match", match_cnt, 1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
